// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: HDLC flag hunt, zero destuffing, LSB-first byte assembly, abort/misalignment detection.
// Define HDLC_RX_CRC_EN to build the CRC-16/X.25 FCS residue check into out_crc_ok.
module hdlc_rx_deframer #(
    parameter int unsigned MIN_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_crc_ok,
    output logic       out_abort
);
    localparam logic [1:0] HUNT = 2'd0, SYNC = 2'd1, DATA = 2'd2;
    localparam logic [7:0] MIN_B = MIN_BYTES[7:0];
    logic [1:0] state;
    logic [6:0] hist;
    logic [7:0] win, sr, sr_n, byte_cnt;
    logic [2:0] ones, bcnt;
    logic flag, seven, stuffed, take, byte_done, crc_good;
    // win is the 8-bit raw history including the bit being sampled now
    always_comb begin
        win = {hist, bit_in};
        sr_n = {bit_in, sr[7:1]};
        flag = win == 8'h7E;
        seven = bit_in && ones >= 3'd6;
        stuffed = !bit_in && ones == 3'd5;
        take = state != HUNT && !flag && !seven && !stuffed;
        byte_done = take && state == DATA && bcnt == 3'd7;
    end
`ifdef HDLC_RX_CRC_EN
    logic [15:0] crc;
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        crc_byte = c;
        for (int i = 0; i < 8; i++)
            crc_byte = (crc_byte[0] ^ d[i]) ? (crc_byte >> 1) ^ 16'h8408 : crc_byte >> 1;
    endfunction
    always_ff @(posedge clk) begin
        if (!rst_n) crc <= 16'hFFFF;
        else if (bit_valid) crc <= flag ? 16'hFFFF : byte_done ? crc_byte(crc, sr_n) : crc;
    end
    assign crc_good = crc == 16'hF0B8;
`else
    assign crc_good = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
            hist <= '0;
            ones <= '0;
            sr <= '0;
            bcnt <= '0;
            byte_cnt <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            out_sof <= 1'b0;
            out_eof <= 1'b0;
            out_crc_ok <= 1'b0;
            out_abort <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof <= 1'b0;
            out_eof <= 1'b0;
            out_crc_ok <= 1'b0;
            out_abort <= 1'b0;
            if (bit_valid) begin
                hist <= win[6:0];
                ones <= bit_in ? ones + {2'b0, ones != 3'd7} : 3'd0;
                if (flag) begin
                    // aligned close: the flag's seven leading bits sit in a partial byte
                    if (state == DATA) begin
                        out_eof <= bcnt == 3'd7 && byte_cnt != 8'd0;
                        out_crc_ok <= bcnt == 3'd7 && byte_cnt != 8'd0 && crc_good && byte_cnt >= MIN_B;
                        out_abort <= bcnt != 3'd7;
                    end
                    state <= SYNC;
                    bcnt <= '0;
                    byte_cnt <= '0;
                end else if (seven) begin
                    out_abort <= state == DATA;
                    state <= HUNT;
                end else if (take) begin
                    state <= DATA;
                    sr <= sr_n;
                    bcnt <= bcnt + 3'd1;
                    if (byte_done) begin
                        out_valid <= 1'b1;
                        out_sof <= byte_cnt == 8'd0;
                        out_data <= sr_n;
                        byte_cnt <= byte_cnt + {7'b0, byte_cnt != 8'hFF};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: random-gap bit stimulus against a frame-level model of the deframer output events.
module tb_hdlc_rx_deframer;
    typedef logic [7:0] bq_t[$];
    localparam int MIN = 3;
    logic clk = 0, rst_n = 0, bit_in = 0, bit_valid = 0;
    logic [7:0] out_data;
    logic out_valid, out_sof, out_eof, out_crc_ok, out_abort;
    int passed = 0, total = 0;
    logic tx[$];
    logic [11:0] exp_q[$], got_q[$];

    always #5 clk = ~clk;

    hdlc_rx_deframer #(.MIN_BYTES(MIN)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
        .out_eof(out_eof), .out_crc_ok(out_crc_ok), .out_abort(out_abort)
    );

    // events: {kind, sof, ok, data}; kind 1 = byte, 2 = end of frame, 3 = abort
    always @(negedge clk) begin
        if (out_valid) got_q.push_back({2'd1, out_sof, 1'b0, out_data});
        if (out_eof) got_q.push_back({2'd2, 1'b0, out_crc_ok, 8'h00});
        if (out_abort) got_q.push_back({2'd3, 10'd0});
        if (out_valid | out_eof | out_abort) begin
            total++;
            if (!$onehot({out_valid, out_eof, out_abort}))
                $display("FAIL exclusive: valid/eof/abort=%b%b%b want one-hot", out_valid, out_eof, out_abort);
            else passed++;
        end
    end

    function automatic logic [15:0] crc16(input bq_t b, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++) begin
                logic fb = c[0] ^ b[i][j];
                c = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        return c;
    endfunction

    function automatic bq_t with_fcs(input bq_t f);
        logic [15:0] c = ~crc16(f, f.size());
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        return f;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t f;
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        return f;
    endfunction

    task automatic put_flag();
        for (int j = 0; j < 8; j++) tx.push_back(j != 0 && j != 7);
    endtask

    task automatic put_payload(input bq_t b, input int xn, input logic [7:0] x);
        logic q[$];
        int ones = 0;
        foreach (b[i]) for (int j = 0; j < 8; j++) q.push_back(b[i][j]);
        for (int j = 0; j < xn; j++) q.push_back(x[j]);
        foreach (q[i]) begin
            tx.push_back(q[i]);
            ones = q[i] ? ones + 1 : 0;
            if (ones == 5) begin
                tx.push_back(1'b0);
                ones = 0;
            end
        end
    endtask

    // Frame model: destuffed payload plus the closing flag's 7 leading bits is cut into bytes;
    // a 7-bit remainder closes the frame, any other remainder is an abort.
    task automatic expect_frame(input bq_t b, input int xn, input logic [7:0] x);
        logic s[$];
        logic [7:0] v;
        logic [15:0] c;
        logic ok;
        int n;
        foreach (b[i]) for (int j = 0; j < 8; j++) s.push_back(b[i][j]);
        for (int j = 0; j < xn; j++) s.push_back(x[j]);
        s.push_back(1'b0);
        repeat (6) s.push_back(1'b1);
        n = s.size() / 8;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) v[j] = s[8*i+j];
            exp_q.push_back({2'd1, i == 0, 1'b0, v});
        end
        if (s.size() % 8 != 7) exp_q.push_back({2'd3, 10'd0});
        else if (n >= 1) begin
            ok = n >= MIN;
`ifdef HDLC_RX_CRC_EN
            if (ok) begin
                c = ~crc16(b, n - 2);
                ok = b[n-2] == c[7:0] && b[n-1] == c[15:8];
            end
`endif
            exp_q.push_back({2'd2, 1'b0, ok, 8'h00});
        end
    endtask

    task automatic run_tx();
        while (tx.size() != 0) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            bit_in = tx.pop_front();
            bit_valid = 1;
            @(negedge clk);
            bit_valid = 0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort} !== 13'd0)
            $display("FAIL reset_during: outputs=%h want 0", {out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort});
        else passed++;
        rst_n = 1;
        @(negedge clk);
        total++;
        if ({out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort} !== 13'd0)
            $display("FAIL reset_after: outputs=%h want 0", {out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort});
        else passed++;
    endtask

    task automatic test_good_frame();
        bq_t f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
        put_flag(); put_payload(f, 0, 0); put_flag();
        expect_frame(f, 0, 0);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL good_frame count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL good_frame ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_stuffing();
        bq_t f = with_fcs('{8'hFF, 8'hF8, 8'h3F});
        put_flag(); put_payload(f, 0, 0); put_flag();
        expect_frame(f, 0, 0);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL stuffing count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL stuffing ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_abort();
        bq_t f = with_fcs('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39});
        put_flag(); put_payload('{8'h55}, 0, 0);
        repeat (8) tx.push_back(1'b1);
        exp_q.push_back({2'd1, 1'b1, 1'b0, 8'h55});
        exp_q.push_back({2'd3, 10'd0});
        put_flag(); put_payload(f, 0, 0); put_flag();
        expect_frame(f, 0, 0);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL abort count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL abort ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_shared_flags();
        bq_t f = with_fcs(rand_bytes(5));
        repeat (3) put_flag();
        put_payload(f, 0, 0); put_flag();
        expect_frame(f, 0, 0);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL shared_flags count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL shared_flags ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_misaligned();
        put_flag(); put_payload('{8'hA5}, 3, 8'b010); put_flag();
        expect_frame('{8'hA5}, 3, 8'b010);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL misaligned count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL misaligned ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_min_bytes();
        bq_t a = '{8'h00, 8'h00};
        bq_t b = with_fcs('{8'hAB});
        put_flag(); put_payload(a, 0, 0); put_flag(); put_payload(b, 0, 0); put_flag();
        expect_frame(a, 0, 0); expect_frame(b, 0, 0);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL min_bytes count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL min_bytes ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_bad_crc();
        bq_t f = with_fcs(rand_bytes(4));
        int k = $urandom_range(0, 15);
        f[4 + k / 8][k % 8] = ~f[4 + k / 8][k % 8];
        put_flag(); put_payload(f, 0, 0); put_flag();
        expect_frame(f, 0, 0);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL bad_crc count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bad_crc ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        put_flag();
        repeat (8) begin
            bq_t f = rand_bytes($urandom_range(1, 6));
            int xn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            logic [7:0] x = 8'($urandom);
            if ($urandom_range(0, 1) == 1) f = with_fcs(f);
            put_payload(f, xn, x); put_flag();
            expect_frame(f, xn, x);
        end
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL random count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL random ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_mid_reset();
        bq_t f = with_fcs(rand_bytes(3));
        put_flag(); put_payload('{8'h12, 8'h34, 8'h56}, 0, 0);
        exp_q.push_back({2'd1, 1'b1, 1'b0, 8'h12});
        exp_q.push_back({2'd1, 1'b0, 1'b0, 8'h34});
        exp_q.push_back({2'd1, 1'b0, 1'b0, 8'h56});
        run_tx();
        rst_n = 0;
        @(negedge clk);
        total++;
        if ({out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort} !== 13'd0)
            $display("FAIL mid_reset_during: outputs=%h want 0", {out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort});
        else passed++;
        rst_n = 1;
        @(negedge clk);
        total++;
        if ({out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort} !== 13'd0)
            $display("FAIL mid_reset_after: outputs=%h want 0", {out_data, out_valid, out_sof, out_eof, out_crc_ok, out_abort});
        else passed++;
        put_payload(rand_bytes(4), 0, 0); put_flag(); put_payload(f, 0, 0); put_flag();
        expect_frame(f, 0, 0);
        run_tx();
        total++;
        if (got_q.size() !== exp_q.size()) $display("FAIL mid_reset count: got %0d want %0d", got_q.size(), exp_q.size());
        else passed++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL mid_reset ev%0d: got %h want %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_stuffing();
        test_abort();
        test_shared_flags();
        test_misaligned();
        test_min_bytes();
        test_bad_crc();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
